// File: rtl/pipelined_id_stage.sv
// RV32I decode stage with a registered ID/EX bundle and valid/ready flow control.
// Provides write-through register bypass, load-use stall, flush and bubble insertion.
//
// Ports: clk/reset (sync, active-high); if_valid/id_ready/if_instr/if_pc from fetch;
//   flush (redirect); wb_en/wb_rd/wb_data register write; ex_valid/ex_ready plus
//   the decoded ex_* bundle toward execute.
// ex_aluop classes: 0 add (address/PC), 1 branch compare, 2 R-type funct,
//   3 I-type funct, 4 pass immediate (LUI).
// ex_memtoreg: 0 ALU, 1 memory, 2 PC+4.
module pipelined_id_stage #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            id_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_fn3,
  output logic            ex_fn7_5,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_aluop,
  output logic [1:0]      ex_memtoreg,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd;
    logic [2:0]      fn3;
    logic            fn7_5;
    logic [6:0]      opcode;
    logic [2:0]      aluop;
    logic [1:0]      memtoreg;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic            illegal;
  } id_ex_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_BR  = 3'd1;
  localparam logic [2:0] ALU_R   = 3'd2;
  localparam logic [2:0] ALU_I   = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  logic [XLEN-1:0] rf_q [NREGS];
  id_ex_t          ex_q, ex_d, dec;

  logic [6:0]      opc;
  logic [RA_W-1:0] rs1_a, rs2_a;
  logic [XLEN-1:0] rs1_v, rs2_v;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            is_lui, is_auipc, is_jal, is_jalr;
  logic            is_br, is_ld, is_st, is_opi, is_op;
  logic            is_fence, is_sys;
  logic            use_rs1, use_rs2;
  logic            hazard, advance;

  assign opc   = if_instr[6:0];
  assign rs1_a = if_instr[15 +: RA_W];
  assign rs2_a = if_instr[20 +: RA_W];

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;
  assign is_fence = opc == 7'b0001111;
  assign is_sys   = opc == 7'b1110011;

  assign imm_i = XLEN'($signed(if_instr[31:20]));
  assign imm_s = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
  assign imm_b = XLEN'($signed({if_instr[31], if_instr[7],
                                if_instr[30:25], if_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({if_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({if_instr[31], if_instr[19:12],
                                if_instr[20], if_instr[30:21], 1'b0}));

  // Same-cycle writeback is forwarded so a value is never read stale.
  assign rs1_v = (rs1_a == '0) ? '0 :
                 (wb_en && wb_rd == rs1_a) ? wb_data : rf_q[rs1_a];
  assign rs2_v = (rs2_a == '0) ? '0 :
                 (wb_en && wb_rd == rs2_a) ? wb_data : rf_q[rs2_a];

  assign use_rs1 = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
  assign use_rs2 = is_br | is_st | is_op;

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.pc     = if_pc;
    dec.rs1    = rs1_v;
    dec.rs2    = rs2_v;
    dec.rd     = if_instr[7 +: RA_W];
    dec.fn3    = if_instr[14:12];
    dec.fn7_5  = if_instr[30];
    dec.opcode = opc;
    unique case (1'b1)
      is_lui: begin
        dec.imm = imm_u; dec.aluop = ALU_LUI;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      is_auipc: begin
        dec.imm = imm_u; dec.aluop = ALU_ADD;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      is_jal: begin
        dec.imm = imm_j; dec.memtoreg = 2'd2;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      is_jalr: begin
        dec.imm = imm_i; dec.memtoreg = 2'd2;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      is_br: begin
        dec.imm = imm_b; dec.aluop = ALU_BR;
        dec.branch = 1'b1;
      end
      is_ld: begin
        dec.imm = imm_i; dec.memtoreg = 2'd1;
        dec.mem_read = 1'b1; dec.alu_src = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_st: begin
        dec.imm = imm_s; dec.mem_write = 1'b1;
        dec.alu_src = 1'b1;
      end
      is_opi: begin
        dec.imm = imm_i; dec.aluop = ALU_I;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      is_op: begin
        dec.aluop = ALU_R; dec.reg_write = 1'b1;
      end
      is_fence, is_sys: begin
        dec.imm = imm_i; dec.alu_src = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // A load in EX cannot forward in time to a dependent consumer here.
  assign hazard = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 &&
                  ((use_rs1 && rs1_a == ex_q.rd) ||
                   (use_rs2 && rs2_a == ex_q.rd));
  assign advance  = !ex_q.valid || ex_ready;
  assign id_ready = flush || (advance && !hazard);

  always_comb begin
    ex_d = ex_q;
    if (flush)
      ex_d = '0;
    else if (advance)
      ex_d = (if_valid && !hazard) ? dec : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1;
  assign ex_rs2_data  = ex_q.rs2;
  assign ex_imm       = ex_q.imm;
  assign ex_rd        = ex_q.rd;
  assign ex_fn3       = ex_q.fn3;
  assign ex_fn7_5     = ex_q.fn7_5;
  assign ex_opcode    = ex_q.opcode;
  assign ex_aluop     = ex_q.aluop;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_branch    = ex_q.branch;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_pipelined_id_stage.sv
// Testbench for pipelined_id_stage: directed scenarios, then random traffic
// checked cycle by cycle against a behavioural decode/pipeline model.
module tb_pipelined_id_stage;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, flush, wb_en;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_fn3, ex_aluop;
  logic        ex_fn7_5;
  logic [6:0]  ex_opcode;
  logic [1:0]  ex_memtoreg;
  logic        ex_branch, ex_mem_read, ex_mem_write;
  logic        ex_alu_src, ex_reg_write, ex_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_fn3(ex_fn3),
    .ex_fn7_5(ex_fn7_5), .ex_opcode(ex_opcode), .ex_aluop(ex_aluop),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic [2:0]  alu;
    logic [1:0]  m2r;
    logic        br, mr, mw, as, rw, ill;
  } bund_t;

  logic [31:0] regs [32];
  bund_t       slot;

  function automatic bund_t outv();
    return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
            ex_fn3, ex_fn7_5, ex_opcode, ex_aluop, ex_memtoreg,
            ex_branch, ex_mem_read, ex_mem_write, ex_alu_src,
            ex_reg_write, ex_illegal};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_en && wb_rd == a) return wb_data;
    return regs[a];
  endfunction

  function automatic bit uses1(input logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  // Decode from the instruction-format rules using plain arithmetic.
  function automatic bund_t model_dec(input logic [31:0] w,
                                      input logic [31:0] pc);
    bund_t b;
    int s, iI, iS, iB, iU, iJ;
    s  = $signed(w);
    iI = s >>> 20;
    iS = (s >>> 25) * 32 + int'(w[11:7]);
    iB = (s >>> 31) * 4096 + int'(w[7]) * 2048
       + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    iU = int'(w & 32'hFFFFF000);
    iJ = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096
       + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    b    = '0;
    b.v  = 1'b1;
    b.pc = pc;
    b.r1 = rdreg(w[19:15]);
    b.r2 = rdreg(w[24:20]);
    b.rd = w[11:7];
    b.f3 = w[14:12];
    b.f7 = w[30];
    b.op = w[6:0];
    case (w[6:0])
      7'h37: begin b.imm = iU; b.alu = 4; b.as = 1; b.rw = 1; end
      7'h17: begin b.imm = iU; b.as = 1; b.rw = 1; end
      7'h6F: begin b.imm = iJ; b.m2r = 2; b.as = 1; b.rw = 1; end
      7'h67: begin b.imm = iI; b.m2r = 2; b.as = 1; b.rw = 1; end
      7'h63: begin b.imm = iB; b.alu = 1; b.br = 1; end
      7'h03: begin
        b.imm = iI; b.m2r = 1; b.mr = 1; b.as = 1; b.rw = 1;
      end
      7'h23: begin b.imm = iS; b.mw = 1; b.as = 1; end
      7'h13: begin b.imm = iI; b.alu = 3; b.as = 1; b.rw = 1; end
      7'h33: begin b.alu = 2; b.rw = 1; end
      7'h0F, 7'h73: begin b.imm = iI; b.as = 1; end
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom);
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    bit    hold, haz, adv, exp_rdy;
    reset = 1; if_valid = 0; ex_ready = 1; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; if_instr = 0; if_pc = 0;
    tick(); tick();
    chk("reset_bundle", outv(), '0);
    reset = 0; #1;
    chk("reset_id_ready", id_ready, 1);

    // addi x1,x0,5
    if_valid = 1; if_instr = 32'h00500093; if_pc = 32'h100;
    tick();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 1);
    chk("addi_alu_src", ex_alu_src, 1);
    chk("addi_reg_write", ex_reg_write, 1);
    chk("addi_pc", ex_pc, 32'h100);

    // add x4,x3,x3 with x3 written the same cycle
    wb_en = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    if_instr = 32'h00318233; if_pc = 32'h104;
    tick();
    wb_en = 0;
    chk("bypass_rs1", ex_rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2", ex_rs2_data, 32'hDEADBEEF);

    // lw x5,0(x2) then add x6,x5,x1
    if_instr = 32'h00012283; if_pc = 32'h108;
    tick();
    chk("lw_mem_read", ex_mem_read, 1);
    if_instr = 32'h00128333; if_pc = 32'h10C; #1;
    chk("lu_stall_ready", id_ready, 0);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_flags", {ex_mem_read, ex_reg_write, ex_alu_src}, 0);
    chk("lu_resume_ready", id_ready, 1);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 6);

    // execute back-pressure for 3 cycles
    ex_ready = 0; if_instr = 32'h00900393; if_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", id_ready, 0);
      tick();
      chk("bp_held_pc", ex_pc, 32'h10C);
    end
    ex_ready = 1; #1;
    chk("bp_ready_high", id_ready, 1);
    tick();
    chk("bp_next_rd", ex_rd, 7);
    chk("bp_next_imm", ex_imm, 9);
    if_valid = 0;
    tick();
    chk("bp_no_dup", ex_valid, 0);

    // flush with a valid bundle and a pending input
    if_valid = 1; if_instr = 32'h00100413; if_pc = 32'h114;
    tick();
    chk("fl_pre_valid", ex_valid, 1);
    if_instr = 32'h00200493; if_pc = 32'h118; flush = 1;
    wb_en = 1; wb_rd = 10; wb_data = 32'h55; #1;
    chk("fl_ready", id_ready, 1);
    tick();
    chk("fl_valid0", ex_valid, 0);
    flush = 0; wb_en = 0; if_valid = 0;
    tick();
    chk("fl_gone", ex_valid, 0);
    if_valid = 1; if_instr = 32'h00050593; if_pc = 32'h11C;
    tick();
    chk("fl_wb_kept", ex_rs1_data, 32'h55);
    chk("fl_next_rd", ex_rd, 11);

    // x0 write ignored; illegal opcode 0x7F
    if_valid = 0; wb_en = 1; wb_rd = 0; wb_data = 32'h1234;
    tick();
    if_valid = 1; if_instr = 32'h0000007F; if_pc = 32'h120;
    tick();
    wb_en = 0;
    chk("x0_rs1", ex_rs1_data, 0);
    chk("x0_rs2", ex_rs2_data, 0);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_ctl", {ex_reg_write, ex_mem_write, ex_mem_read, ex_branch}, 0);
    chk("ill_valid", ex_valid, 1);

    // reset during a transfer and a register write
    if_instr = 32'h00060693; if_pc = 32'h124;
    wb_en = 1; wb_rd = 12; wb_data = 32'hAA; reset = 1;
    tick();
    chk("rst_mid_valid", ex_valid, 0);
    reset = 0; wb_en = 0;
    tick();
    chk("rst_no_commit", ex_rs1_data, 0);
    chk("rst_next_rd", ex_rd, 13);

    // random traffic against the model
    if_valid = 0; reset = 1;
    tick();
    reset = 0;
    foreach (regs[i]) regs[i] = 0;
    slot = '0; hold = 0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        if_valid = $urandom_range(0, 3) != 0;
        if_instr = gen();
        if_pc    = $urandom & 32'hFFFFFFFC;
      end
      ex_ready = $urandom_range(0, 9) < 7;
      flush    = $urandom_range(0, 19) == 0;
      wb_en    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      #1;
      haz = slot.v && slot.mr && slot.rd != 0 &&
            ((uses1(if_instr[6:0]) && if_instr[19:15] == slot.rd) ||
             (uses2(if_instr[6:0]) && if_instr[24:20] == slot.rd));
      adv = !slot.v || ex_ready;
      exp_rdy = flush || (adv && !haz);
      chk("rand_id_ready", id_ready, exp_rdy);
      if (flush) slot = '0;
      else if (adv) slot = (if_valid && !haz) ?
                           model_dec(if_instr, if_pc) : '0;
      hold = if_valid && !exp_rdy;
      if (wb_en && wb_rd != 0) regs[wb_rd] = wb_data;
      tick();
      chk("rand_bundle", outv(), slot);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
